// File: rtl/io_timer.sv
// Interval timer on the IO bus: prescaled 32-bit up-counter, compare match, W1C status, level interrupt.
// Latency: register writes take effect on the next clk edge; reads return data one cycle after the strobe.
// Backpressure: none. The bus is always accepted, and rdata passes rdata_in through whenever no read is pending.
module io_timer #(
    parameter logic [13:0] TMR_BASE = 14'h3F90
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_io_we,
    input  logic [15:2] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [15:2] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic        interrupt_timer
);

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_CMP  = 2'd1;
    localparam logic [1:0] A_CNT  = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    logic        en, autoreload, ie, match;
    logic [7:0]  presc, pcnt;
    logic [31:0] cmp, cnt;
    logic        rd_sel;
    logic [1:0]  rd_idx;

    logic [13:0] wr_off, rd_off;
    logic        wr_hit, rd_hit;
    logic        wr_ctrl, wr_cmp, wr_cnt, wr_stat;
    logic        tick, cmp_hit;

    // An offset from the base that is below 4 selects one of the four words.
    assign wr_off  = dma_io_wadr - TMR_BASE;
    assign rd_off  = dma_io_radr - TMR_BASE;
    assign wr_hit  = dma_io_we && (wr_off[13:2] == 12'd0);
    assign rd_hit  = dma_io_radr_en && (rd_off[13:2] == 12'd0);
    assign wr_ctrl = wr_hit && (wr_off[1:0] == A_CTRL);
    assign wr_cmp  = wr_hit && (wr_off[1:0] == A_CMP);
    assign wr_cnt  = wr_hit && (wr_off[1:0] == A_CNT);
    assign wr_stat = wr_hit && (wr_off[1:0] == A_STAT);

    assign tick    = en && (pcnt == presc);
    assign cmp_hit = tick && (cnt == cmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en         <= 1'b0;
            autoreload <= 1'b0;
            ie         <= 1'b0;
            presc      <= 8'd0;
            pcnt       <= 8'd0;
            cmp        <= 32'd0;
            cnt        <= 32'd0;
            match      <= 1'b0;
            rd_sel     <= 1'b0;
            rd_idx     <= 2'd0;
        end else begin
            // A CPU write to CTRL overrides the one-shot disable.
            if (wr_ctrl) begin
                en         <= dma_io_wdata[0];
                autoreload <= dma_io_wdata[1];
                ie         <= dma_io_wdata[2];
                presc      <= dma_io_wdata[15:8];
            end else if (cmp_hit && !autoreload) begin
                en <= 1'b0;
            end

            if (wr_ctrl || !en || tick)
                pcnt <= 8'd0;
            else
                pcnt <= pcnt + 8'd1;

            if (wr_cmp)
                cmp <= dma_io_wdata;

            // A CPU write to CNT overrides both increment and reload.
            if (wr_cnt)
                cnt <= dma_io_wdata;
            else if (cmp_hit) begin
                if (autoreload)
                    cnt <= 32'd0;
            end else if (tick)
                cnt <= cnt + 32'd1;

            // A hardware set beats a same-cycle W1C, so no match is lost.
            if (cmp_hit)
                match <= 1'b1;
            else if (wr_stat && dma_io_wdata[0])
                match <= 1'b0;

            rd_sel <= rd_hit;
            rd_idx <= rd_off[1:0];
        end
    end

    assign interrupt_timer = match & ie;

    always_comb begin
        dma_io_rdata = dma_io_rdata_in;
        if (rd_sel) begin
            case (rd_idx)
                A_CTRL:  dma_io_rdata = {16'd0, presc, 5'd0, ie, autoreload, en};
                A_CMP:   dma_io_rdata = cmp;
                A_CNT:   dma_io_rdata = cnt;
                default: dma_io_rdata = {31'd0, match};
            endcase
        end
    end

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: an abstract per-cycle model checked on every falling edge,
// plus hand-computed literal expectations at key points of each scenario.
module tb_io_timer;

    localparam logic [13:0] BASE = 14'h3F90;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dma_io_we;
    logic [15:2] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [15:2] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;
    logic        interrupt_timer;

    int n_chk  = 0;
    int n_pass = 0;

    io_timer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dma_io_we       (dma_io_we),
        .dma_io_wadr     (dma_io_wadr),
        .dma_io_wdata    (dma_io_wdata),
        .dma_io_radr     (dma_io_radr),
        .dma_io_radr_en  (dma_io_radr_en),
        .dma_io_rdata_in (dma_io_rdata_in),
        .dma_io_rdata    (dma_io_rdata),
        .interrupt_timer (interrupt_timer)
    );

    always #5 clk = ~clk;

    // Abstract model: prescaler is "clocks since restart modulo (presc+1)".
    logic        m_en, m_ar, m_ie, m_match;
    logic [7:0]  m_presc;
    logic [31:0] m_cmp, m_cnt;
    int          m_elapsed;
    logic        m_rd_pend;
    int          m_rd_idx;

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_match = 0; m_presc = 0;
        m_cmp = 0; m_cnt = 0; m_elapsed = 0; m_rd_pend = 0; m_rd_idx = 0;
    endtask

    function automatic logic [31:0] m_read(int idx);
        case (idx)
            0:       return {16'h0, m_presc, 5'h0, m_ie, m_ar, m_en};
            1:       return m_cmp;
            2:       return m_cnt;
            default: return {31'h0, m_match};
        endcase
    endfunction

    task automatic model_step();
        int woff, roff;
        logic tick, hit, wr;
        logic        n_en, n_ar, n_ie, n_match;
        logic [7:0]  n_presc;
        logic [31:0] n_cmp, n_cnt;
        woff = int'(dma_io_wadr) - int'(BASE);
        roff = int'(dma_io_radr) - int'(BASE);
        wr   = dma_io_we && woff >= 0 && woff < 4;
        tick = m_en && ((m_elapsed % (int'(m_presc) + 1)) == int'(m_presc));
        hit  = tick && (m_cnt == m_cmp);
        n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_presc = m_presc;
        n_cmp = m_cmp; n_cnt = m_cnt; n_match = m_match;
        if (tick) n_cnt = hit ? (m_ar ? 32'd0 : m_cnt) : m_cnt + 32'd1;
        if (hit && !m_ar) n_en = 0;
        if (wr && woff == 3 && dma_io_wdata[0]) n_match = 0;
        if (hit) n_match = 1;
        if (wr && woff == 0) begin
            n_en = dma_io_wdata[0]; n_ar = dma_io_wdata[1];
            n_ie = dma_io_wdata[2]; n_presc = dma_io_wdata[15:8];
        end
        if (wr && woff == 1) n_cmp = dma_io_wdata;
        if (wr && woff == 2) n_cnt = dma_io_wdata;
        m_elapsed = ((wr && woff == 0) || !m_en) ? 0 : m_elapsed + 1;
        m_rd_pend = dma_io_radr_en && roff >= 0 && roff < 4;
        m_rd_idx  = roff;
        m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_presc = n_presc;
        m_cmp = n_cmp; m_cnt = n_cnt; m_match = n_match;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    logic run_cmp = 1'b0;
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cyc_rdata", dma_io_rdata, m_rd_pend ? m_read(m_rd_idx) : dma_io_rdata_in);
            chk("cyc_irq", {31'h0, interrupt_timer}, {31'h0, m_match & m_ie});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int off, logic [31:0] d);
        dma_io_we = 1; dma_io_wadr = BASE + 14'(off); dma_io_wdata = d;
        cyc();
        dma_io_we = 0;
    endtask

    task automatic rd_addr(logic [13:0] a, output logic [31:0] v);
        dma_io_radr_en = 1; dma_io_radr = a;
        cyc();
        dma_io_radr_en = 0;
        v = dma_io_rdata;
    endtask

    task automatic rd(int off, output logic [31:0] v);
        rd_addr(BASE + 14'(off), v);
    endtask

    logic [31:0] v;

    initial begin
        model_reset();
        rst_n = 0; dma_io_we = 0; dma_io_wadr = 0; dma_io_wdata = 0;
        dma_io_radr = 0; dma_io_radr_en = 0; dma_io_rdata_in = 32'h0;
        repeat (2) cyc();
        rst_n = 1;
        run_cmp = 1;
        cyc();

        // Reset values and pass-through
        for (int i = 0; i < 4; i++) begin
            rd(i, v);
            chk($sformatf("reset_reg%0d", i), v, 32'h0);
        end
        dma_io_rdata_in = 32'hA5A5_0001;
        rd_addr(14'h3F80, v);
        chk("led_passthru", v, 32'hA5A5_0001);
        dma_io_rdata_in = 32'hDEAD_BEEF;
        #1;
        chk("comb_passthru", dma_io_rdata, 32'hDEAD_BEEF);
        dma_io_rdata_in = 32'h0;

        // Prescaled one-shot: match on the 12th edge after the CTRL write
        wr(1, 32'd3);
        wr(0, 32'h0000_0201);
        repeat (10) cyc();
        rd(3, v);
        chk("oneshot_no_match_11", v, 32'h0);
        rd(3, v);
        chk("oneshot_match_12", v, 32'h1);
        rd(2, v);
        chk("oneshot_cnt_hold", v, 32'd3);
        rd(0, v);
        chk("oneshot_en_clr", v, 32'h0000_0200);
        chk("oneshot_irq", {31'h0, interrupt_timer}, 32'h0);

        // Auto-reload with interrupt
        wr(3, 32'h1);
        wr(2, 32'h0);
        wr(1, 32'd1);
        wr(0, 32'h0000_0007);
        rd(2, v);
        chk("ar_cnt1", v, 32'd1);
        rd(3, v);
        chk("ar_match", v, 32'h1);
        chk("ar_irq_set", {31'h0, interrupt_timer}, 32'h1);
        wr(3, 32'h1);
        chk("ar_irq_clr", {31'h0, interrupt_timer}, 32'h0);
        cyc();
        chk("ar_irq_reassert", {31'h0, interrupt_timer}, 32'h1);

        // W1C in the same cycle as a match tick
        wr(3, 32'h1);
        chk("w1c_plain_clr", {31'h0, interrupt_timer}, 32'h0);
        wr(3, 32'h1);
        chk("w1c_collide_irq", {31'h0, interrupt_timer}, 32'h1);
        rd(3, v);
        chk("w1c_collide_match", v, 32'h1);

        // CNT write priority over a tick, then wrap to 0 without a match
        wr(0, 32'h0);
        wr(1, 32'd5);
        wr(3, 32'h1);
        wr(0, 32'h0000_0101);
        cyc();
        wr(2, 32'hFFFF_FFFE);
        rd(2, v);
        chk("cnt_wr_prio", v, 32'hFFFF_FFFE);
        repeat (3) cyc();
        rd(2, v);
        chk("cnt_wrap", v, 32'h0);
        rd(3, v);
        chk("wrap_no_match", v, 32'h0);

        // Asynchronous reset while running at CNT=7 with the interrupt up
        wr(0, 32'h0);
        wr(2, 32'd7);
        wr(1, 32'd7);
        wr(0, 32'h0000_0005);
        cyc();
        chk("pre_rst_irq", {31'h0, interrupt_timer}, 32'h1);
        wr(1, 32'd100);
        wr(0, 32'h0000_2005);
        repeat (3) cyc();
        dma_io_rdata_in = 32'h1234_5678;
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_irq", {31'h0, interrupt_timer}, 32'h0);
        chk("async_rst_rdata", dma_io_rdata, 32'h1234_5678);
        repeat (3) cyc();
        rst_n = 1;
        repeat (20) cyc();
        for (int i = 0; i < 4; i++) begin
            rd(i, v);
            chk($sformatf("post_rst_reg%0d", i), v, 32'h0);
        end
        chk("post_rst_irq", {31'h0, interrupt_timer}, 32'h0);

        run_cmp = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/io_timer.md
Name: io_timer

Overview:
- Memory-mapped interval timer on the IO bus, with a 32-bit up-counter, an 8-bit prescaler, a compare match, a sticky status flag and an interrupt output.
- Sits directly upstream of the LED IO block in the read-data daisy chain: this block's dma_io_rdata drives the LED block's dma_io_rdata_in.
- Shares the IO write and read address buses with the other IO blocks.

Parameters:
- TMR_BASE, 14'h3F90, word address of CTRL. Registers occupy TMR_BASE+0 through TMR_BASE+3; all four lie outside the LED word 14'h3F80.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- dma_io_we  in  1  IO write strobe.
- dma_io_wadr  in  [15:2]  IO write word address.
- dma_io_wdata  in  32  IO write data.
- dma_io_radr  in  [15:2]  IO read word address.
- dma_io_radr_en  in  1  IO read strobe.
- dma_io_rdata_in  in  32  read data from the previous block in the chain.
- dma_io_rdata  out  32  read data to the next block in the chain.
- interrupt_timer  out  1  level interrupt, equal to STATUS.match AND CTRL.ie.

Behaviour:
- Reset: async and active-low. All registers, the prescaler counter, the read-select flop and interrupt_timer go to 0.
- Register map (word addresses):
  - +0 CTRL, read/write: bit0 en, bit1 autoreload, bit2 ie, bits[15:8] presc. All other bits read 0.
  - +1 CMP, read/write, 32 bits.
  - +2 CNT, read/write, 32 bits.
  - +3 STATUS: bit0 match. Writing 1 clears it (W1C); writing 0 has no effect. Other bits read 0.
- Write: when dma_io_we=1 and dma_io_wadr matches a register, that register updates on the next clk edge.
- Read: when dma_io_radr_en=1 and dma_io_radr hits one of the 4 words, a select flop is set for exactly one cycle.
  - In that next cycle, dma_io_rdata = the current value of the addressed register (index also flopped).
  - Otherwise dma_io_rdata = dma_io_rdata_in, combinationally.
  - Read latency is 1 cycle. Reads have no side effects.
- Prescaler: an 8-bit counter pcnt runs while en=1.
  - tick=1 when pcnt==presc, and pcnt then returns to 0.
  - tick occurs every presc+1 clocks. presc=0 gives a tick every clock.
  - pcnt is cleared on any CTRL write and whenever en=0.
- Counter: on tick, CNT increments by 1. 0xFFFFFFFF wraps to 0 silently (no flag).
- Match: on a tick with CNT==CMP:
  - STATUS.match is set to 1.
  - If autoreload=1, CNT loads 0 instead of incrementing and en stays 1.
  - If autoreload=0 (one-shot), CNT holds its value and en clears to 0 in the same edge.
- Simultaneous events, in priority order:
  - A CPU write to CNT wins over a tick increment or reload in the same cycle.
  - A CPU write to CTRL wins over the one-shot en clear.
  - Hardware set of match wins over a W1C clear in the same cycle, so no event is lost.
- en=0: CNT and pcnt are frozen/cleared as above; match and the interrupt keep their state.
- interrupt_timer is registered-equivalent: it is combinational from flops only, with no bus-input path.
- Reset asserted mid-count: everything returns to 0 immediately. No ticks occur until software sets en.

Test Plan:
- Reset and pass-through:
  - After reset, reading +0..+3 -> all 0.
  - Read radr=14'h3F80 with rdata_in=32'hA5A5_0001 -> dma_io_rdata=32'hA5A5_0001 in the following cycle.
  - With radr_en=0, rdata follows rdata_in combinationally.
- Prescaled one-shot:
  - Setup: CMP=3, CTRL=32'h0000_0201 (presc=2, en=1).
  - Required: CNT increments every 3 clocks and match sets on the 4th tick (12 clocks after the CTRL write).
  - Required: en reads 0, CNT holds 3, interrupt_timer=0 (ie=0).
- Auto-reload with interrupt:
  - Setup: CMP=1, CTRL=32'h0000_0007 (presc=0).
  - Required: CNT sequence 0,1,0,1...; match sets on the first match.
  - Required: interrupt_timer=1 until W1C write STATUS=1, then 0. It re-asserts at the next match.
- W1C collision: issue a STATUS=1 write in the exact cycle of a match tick -> match remains 1.
- CNT write priority and wrap:
  - Write CNT=32'hFFFF_FFFE on a tick cycle -> reads 32'hFFFF_FFFE.
  - Two further ticks -> 0 with match=0 (CMP=5).
- Reset mid-operation: assert rst_n=0 while running at CNT=7 -> all registers and interrupt_timer are 0 asynchronously, and remain idle after release.
